// File: rtl/systolic_sequencer.sv
// Job sequencer for a NUM_ROWS x NUM_COLS systolic array: clears the accumulators,
// streams K operand vectors through per-lane skew delay lines, then waits out the array drain.
module systolic_sequencer #(
   parameter int INPUT_WIDTH  = 32,
   parameter int WEIGHT_WIDTH = 32,
   parameter int NUM_ROWS     = 16,
   parameter int NUM_COLS     = 16,
   parameter int K_WIDTH      = 16,
   parameter int PE_LATENCY   = 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     start_i,
   input  logic [K_WIDTH-1:0]                       k_len_i,
   output logic                                     busy_o,
   output logic                                     done_o,
   input  logic                                     op_valid_i,
   output logic                                     op_ready_o,
   input  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]     a_vec_i,
   input  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]    b_vec_i,
   output logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]     arr_input_o,
   output logic [NUM_ROWS-1:0]                      arr_input_valid_o,
   output logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]    arr_weight_o,
   output logic [NUM_COLS-1:0]                      arr_weight_valid_o,
   output logic                                     arr_rst_n_o
);

   localparam int DRAIN_LEN = NUM_ROWS + NUM_COLS - 2 + PE_LATENCY;
   localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   state_t               state, state_next;
   logic [K_WIDTH-1:0]   k_len, xfer_cnt;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 xfer, last_xfer, drain_end, clearing;

   assign xfer      = op_ready_o & op_valid_i;
   // Compare against k_len-1 so the counter never has to hold k_len itself (no wrap at max).
   assign last_xfer = xfer && (xfer_cnt == k_len - K_WIDTH'(1));
   assign drain_end = (drain_cnt == DRAIN_W'(DRAIN_LEN - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = CLEAR;
         CLEAR:   state_next = (k_len == '0) ? DONE : FEED;
         FEED:    if (last_xfer) state_next = DRAIN;
         DRAIN:   if (drain_end) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o     = 1'b1;
      done_o     = 1'b0;
      op_ready_o = 1'b0;
      clearing   = 1'b0;
      case (state)
         IDLE:    busy_o     = 1'b0;
         CLEAR:   clearing   = 1'b1;
         FEED:    op_ready_o = 1'b1;
         DONE:    done_o     = 1'b1;
         default: ;
      endcase
   end

   assign arr_rst_n_o = ~(rst_i | clearing);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         k_len     <= '0;
         xfer_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (state == IDLE && start_i) k_len <= k_len_i;
         if (state == CLEAR)           xfer_cnt <= '0;
         else if (xfer)                xfer_cnt <= last_xfer ? '0 : xfer_cnt + K_WIDTH'(1);
         if (state == DRAIN)           drain_cnt <= drain_cnt + DRAIN_W'(1);
         else                          drain_cnt <= '0;
      end
   end

   // Lane r is r+1 stages deep; only the valid bits need reset, data under valid=0 is don't-care.
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      logic [r:0]             vld;
      logic [INPUT_WIDTH-1:0] dat [0:r];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld <= '0;
         end else begin
            vld[0] <= xfer;
            for (int s = 1; s <= r; s++) vld[s] <= vld[s-1];
         end
      end

      always_ff @(posedge clk_i) begin
         dat[0] <= a_vec_i[r];
         for (int s = 1; s <= r; s++) dat[s] <= dat[s-1];
      end

      assign arr_input_o[r]       = dat[r];
      assign arr_input_valid_o[r] = vld[r];
   end

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      logic [c:0]              vld;
      logic [WEIGHT_WIDTH-1:0] dat [0:c];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld <= '0;
         end else begin
            vld[0] <= xfer;
            for (int s = 1; s <= c; s++) vld[s] <= vld[s-1];
         end
      end

      always_ff @(posedge clk_i) begin
         dat[0] <= b_vec_i[c];
         for (int s = 1; s <= c; s++) dat[s] <= dat[s-1];
      end

      assign arr_weight_o[c]       = dat[c];
      assign arr_weight_valid_o[c] = vld[c];
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized scoreboard bench for systolic_sequencer: a job-timeline model predicts control
// outputs each cycle and queues every skewed lane element with the cycle it is due.
module tb_systolic_sequencer;

   localparam int IW    = 8;
   localparam int WW    = 8;
   localparam int NR    = 4;
   localparam int NC    = 4;
   localparam int KW    = 4;
   localparam int PL    = 1;
   localparam int DRAIN = NR + NC - 2 + PL;

   logic                    clk = 1'b0;
   logic                    rst_i = 1'b0;
   logic                    start_i = 1'b0;
   logic [KW-1:0]           k_len_i = '0;
   logic                    op_valid_i = 1'b0;
   logic [NR-1:0][IW-1:0]   a_vec_i = '0;
   logic [NC-1:0][WW-1:0]   b_vec_i = '0;
   logic                    busy_o, done_o, op_ready_o, arr_rst_n_o;
   logic [NR-1:0][IW-1:0]   arr_input_o;
   logic [NR-1:0]           arr_input_valid_o;
   logic [NC-1:0][WW-1:0]   arr_weight_o;
   logic [NC-1:0]           arr_weight_valid_o;

   systolic_sequencer #(
      .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .NUM_ROWS(NR), .NUM_COLS(NC),
      .K_WIDTH(KW), .PE_LATENCY(PL)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
      .busy_o(busy_o), .done_o(done_o), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
      .a_vec_i(a_vec_i), .b_vec_i(b_vec_i),
      .arr_input_o(arr_input_o), .arr_input_valid_o(arr_input_valid_o),
      .arr_weight_o(arr_weight_o), .arr_weight_valid_o(arr_weight_valid_o),
      .arr_rst_n_o(arr_rst_n_o)
   );

   typedef struct {
      int due;
      int side;
      int lane;
      int data;
   } item_t;

   typedef struct {
      bit rst;
      bit busy;
      bit done;
      bit ready;
      bit rst_n;
   } ctrl_t;

   item_t in_q[$];
   ctrl_t ctrl_q[$];
   int    cyc = 0;
   int    n_checks = 0;
   int    n_pass = 0;
   bit    job_on = 1'b0;
   int    js, jk, nx, last;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
   endtask

   // Reference model: a job is a timeline (clear at +1, feed until k transfers, DRAIN quiet
   // cycles, then one done cycle), evaluated on the inputs seen in each cycle.
   always @(negedge clk) begin
      ctrl_t e;
      e.rst = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b0; e.rst_n = 1'b1;
      if (rst_i) begin
         job_on = 1'b0;
         in_q.delete();
         e.rst   = 1'b1;
         e.rst_n = 1'b0;
      end else if (!job_on) begin
         if (start_i) begin
            job_on = 1'b1; js = cyc; jk = int'(k_len_i); nx = 0; last = -1;
         end
      end else begin
         e.busy = 1'b1;
         if (cyc - js == 1) begin
            e.rst_n = 1'b0;
         end else if (jk == 0) begin
            e.done = 1'b1; job_on = 1'b0;
         end else if (last < 0) begin
            e.ready = 1'b1;
            if (op_valid_i) begin
               for (int i = 0; i < NR; i++) in_q.push_back('{cyc + i + 1, 0, i, int'(a_vec_i[i])});
               for (int j = 0; j < NC; j++) in_q.push_back('{cyc + j + 1, 1, j, int'(b_vec_i[j])});
               nx++;
               if (nx == jk) last = cyc;
            end
         end else if (cyc - last > DRAIN) begin
            e.done = 1'b1; job_on = 1'b0;
         end
      end
      ctrl_q.push_back(e);
   end

   task automatic checkLane(input int side, input int lane, input bit v, input int data);
      int    idx;
      string tag;
      idx = -1;
      tag = $sformatf("%s%0d", (side == 0) ? "in" : "wt", lane);
      for (int k = 0; k < in_q.size(); k++)
         if (in_q[k].side == side && in_q[k].lane == lane) begin idx = k; break; end
      if (v) begin
         if (idx < 0) begin
            checkOutput({tag, "_unexpected_valid"}, int'(v), 0);
         end else begin
            checkOutput({tag, "_arrival_cycle"}, cyc, in_q[idx].due);
            checkOutput({tag, "_data"}, data, in_q[idx].data);
            in_q.delete(idx);
         end
      end else if (idx >= 0 && in_q[idx].due <= cyc) begin
         checkOutput({tag, "_missing_valid"}, int'(v), 1);
         in_q.delete(idx);
      end
   endtask

   // Monitor: runs just after the model for the same cycle and consumes its predictions.
   always @(negedge clk) begin
      ctrl_t e;
      #1;
      if (ctrl_q.size() == 0) begin
         checkOutput("ctrl_queue_size", 0, 1);
      end else begin
         e = ctrl_q.pop_front();
         checkOutput("busy", int'(busy_o), int'(e.busy));
         checkOutput("done", int'(done_o), int'(e.done));
         checkOutput("op_ready", int'(op_ready_o), int'(e.ready));
         checkOutput("arr_rst_n", int'(arr_rst_n_o), int'(e.rst_n));
         if (e.rst) begin
            checkOutput("in_valid_in_reset", int'(arr_input_valid_o), 0);
            checkOutput("wt_valid_in_reset", int'(arr_weight_valid_o), 0);
         end else begin
            for (int i = 0; i < NR; i++) checkLane(0, i, arr_input_valid_o[i], int'(arr_input_o[i]));
            for (int j = 0; j < NC; j++) checkLane(1, j, arr_weight_valid_o[j], int'(arr_weight_o[j]));
         end
      end
   end

   task automatic randData();
      for (int i = 0; i < NR; i++) a_vec_i[i] = IW'($urandom);
      for (int j = 0; j < NC; j++) b_vec_i[j] = WW'($urandom);
   endtask

   // One job: start with length k, op_valid at valid_pct% from relative cycle first_valid on,
   // stray start pulses at start_pct% while busy, optional reset at relative cycle rst_at.
   task automatic applyStimulus(input int k, input int valid_pct, input int start_pct,
                                input int rst_at, input int first_valid);
      int rel;
      @(posedge clk); #1;
      start_i    = 1'b1;
      k_len_i    = KW'(k);
      op_valid_i = 1'b0;
      randData();
      rel = 0;
      forever begin
         @(posedge clk); #1;
         rel++;
         start_i = 1'b0;
         if (!job_on) break;
         if (rel == rst_at) begin
            rst_i      = 1'b1;
            op_valid_i = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_i = 1'b0;
            break;
         end
         if (rel > 400) begin
            n_checks++;
            $display("[TB] FAIL job_timeout: job of length %0d still running after %0d cycles", k, rel);
            rst_i = 1'b1;
            @(posedge clk); #1 rst_i = 1'b0;
            break;
         end
         start_i    = ($urandom_range(99) < start_pct);
         k_len_i    = KW'($urandom);
         op_valid_i = (rel >= first_valid) && ($urandom_range(99) < valid_pct);
         randData();
      end
      op_valid_i = 1'b0;
   endtask

   initial begin
      int pct;
      #2 rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      $display("[TB] reset released, running directed jobs");
      applyStimulus(3, 100, 0, -1, 0);
      applyStimulus(2, 100, 0, -1, 4);
      applyStimulus(0, 100, 0, -1, 0);
      applyStimulus(3, 100, 100, -1, 0);
      applyStimulus(3, 100, 0, 7, 0);
      applyStimulus(3, 100, 0, -1, 0);
      applyStimulus(15, 100, 0, -1, 0);
      applyStimulus(15, 60, 50, -1, 0);
      $display("[TB] running randomized jobs");
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(2))
            0:       pct = 100;
            1:       pct = 70;
            default: pct = 30;
         endcase
         applyStimulus($urandom_range(15), pct, 25,
                       ($urandom_range(9) == 0) ? int'($urandom_range(20, 2)) : -1, 0);
      end
      repeat (12) @(posedge clk);
      #1 checkOutput("scoreboard_empty", in_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, the bit width of one array input (A) element.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 32, the bit width of one array weight (B) element.
REQ-003 SHALL have parameters NUM_ROWS and NUM_COLS, default 16 each, which set the array dimensions.
REQ-004 SHALL have parameter K_WIDTH, default 16, the width of the inner-dimension length.
REQ-005 SHALL have parameter PE_LATENCY, default 1, the cycles a PE takes to pass its operands to its neighbour.
REQ-006 clk_i  in  1  single clock; all state is updated on its rising edge.
REQ-007 rst_i  in  1  reset, asynchronous and active-high.
REQ-008 start_i  in  1  one-cycle job start request; sampled only in IDLE.
REQ-009 k_len_i  in  K_WIDTH  number of operand vectors in the job; latched on an accepted start.
REQ-010 busy_o  out  1  high in every state except IDLE.
REQ-011 done_o  out  1  one-cycle pulse when the job completes.
REQ-012 op_valid_i  in  1  operand vector pair is valid.
REQ-013 op_ready_o  out  1  sequencer accepts an operand pair this cycle.
REQ-014 a_vec_i  in  INPUT_WIDTH x NUM_ROWS  A column slice, one element per array row.
REQ-015 b_vec_i  in  WEIGHT_WIDTH x NUM_COLS  B row slice, one element per array column.
REQ-016 arr_input_o / arr_input_valid_o  out  INPUT_WIDTH / 1 x NUM_ROWS  skewed left-edge feed to the array.
REQ-017 arr_weight_o / arr_weight_valid_o  out  WEIGHT_WIDTH / 1 x NUM_COLS  skewed top-edge feed to the array.
REQ-018 arr_rst_n_o  out  1  active-low accumulator clear driven to the array.

Function
REQ-019 SHALL implement the FSM states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-020 IDLE: when start_i=1, SHALL latch k_len_i and move to CLEAR; otherwise SHALL stay in IDLE.
REQ-021 CLEAR: SHALL last exactly 1 cycle with arr_rst_n_o=0, then move to FEED (k_len>0) or DONE (k_len=0).
REQ-022 FEED: SHALL drive op_ready_o=1; a transfer SHALL occur when op_valid_i=1 and op_ready_o=1.
REQ-023 FEED: SHALL count transfers and, on the transfer that makes the count equal k_len, move to DRAIN.
REQ-024 FEED: a cycle with op_valid_i=0 SHALL insert a bubble (valid=0) into the skew chains; the transfer count SHALL be unchanged.
REQ-025 DRAIN: SHALL hold op_ready_o=0 and count exactly NUM_ROWS+NUM_COLS-2+PE_LATENCY cycles, then move to DONE.
REQ-026 DONE: SHALL drive done_o=1 for 1 cycle, then return to IDLE.
REQ-027 Skew: row i element and valid SHALL appear on arr_input_o[i] / arr_input_valid_o[i] exactly i+1 cycles after transfer.
REQ-028 Skew: column j element and valid SHALL appear on arr_weight_o[j] / arr_weight_valid_o[j] exactly j+1 cycles after transfer.
REQ-029 Skew chains SHALL shift every cycle in all states; valid=0 enters the chains in every cycle without a transfer.
REQ-030 Data in skew stages holding valid=0 is don't-care, but valid=0 SHALL always propagate.
REQ-031 start_i SHALL be ignored while busy_o=1; k_len_i changes after the latch SHALL have no effect on the running job.
REQ-032 The transfer counter SHALL be K_WIDTH bits and SHALL NOT wrap; k_len=2^K_WIDTH-1 SHALL be supported.
REQ-033 arr_rst_n_o SHALL be 1 in every state except CLEAR and reset.

Reset
REQ-034 While rst_i=1, the FSM SHALL be in IDLE, all skew valids and counters SHALL be 0, and busy_o, done_o and op_ready_o SHALL be 0.
REQ-035 While rst_i=1, arr_rst_n_o SHALL be 0, asynchronously.
REQ-036 Reset asserted mid-job (any state) SHALL abort the job with no done_o pulse; all skew valids SHALL read 0 on the first cycle after release.

Verification (NUM_ROWS=NUM_COLS=4, PE_LATENCY=1, drain=7; start_i at cycle 0)
REQ-037 k_len=3, op_valid_i constant 1 -> arr_rst_n_o=0 at cycle 1; transfers at cycles 2-4; DRAIN at cycles 5-11; done_o=1 at cycle 12 only; busy_o=1 at cycles 1-12.
REQ-038 Same job with a=[1,2,3,4] transferred at cycle 2 -> arr_input_o[0]=1 at cycle 3, [1]=2 at 4, [2]=3 at 5, [3]=4 at 6, each with valid=1; the weight side behaves identically.
REQ-039 k_len=2 with op_valid_i=0 at cycles 2-3 and 1 from cycle 4 -> transfers at cycles 4-5; arr_input_valid_o[0]=0 at cycles 3-4 and 1 at cycles 5-6; done_o=1 at cycle 13.
REQ-040 k_len=0 -> CLEAR at cycle 1, done_o=1 at cycle 2, no valid ever asserted, op_ready_o never 1.
REQ-041 start_i pulsed at cycle 6 of a running job -> ignored; done_o pulses once and k_len is unchanged.
REQ-042 rst_i asserted at cycle 7 of the k_len=3 job -> arr_rst_n_o=0 and all valids 0 immediately; after release FSM is in IDLE, no done_o pulse, and a new start runs normally.
